dma_controller: RTL and testbench
=================================

DMA_CONTROLLER -- requirements
Module: dma_controller

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_WIDTH, 16, address bus width.
- DATA_WIDTH, 8, data bus width.
- LEN_WIDTH, 8, transfer length counter width.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; reset is synchronous and active-high.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle pulse that launches a transfer.
- src_addr, in, ADDR_WIDTH, source base address; sampled on start.
- dst_addr, in, ADDR_WIDTH, destination base address; sampled on start.
- len, in, LEN_WIDTH, byte count; sampled on start.
- bus_req, out, 1, DMA requests ownership of the data and address buses.
- bus_gnt, in, 1, CPU grants the buses; asserted only at T0 instruction boundaries, held while owned.
- addr, out, ADDR_WIDTH, DMA address; drives the bus only while addr_oe=1.
- addr_oe, out, 1, DMA drives the address bus.
- data_in, in, DATA_WIDTH, data bus value during a read.
- data_out, out, DATA_WIDTH, holding register value; driven only while data_oe=1.
- data_oe, out, 1, DMA drives the data bus.
- mem_oe, out, 1, memory output enable.
- mem_we, out, 1, memory write enable.
- busy, out, 1, transfer in progress.
- done, out, 1, one-cycle pulse when a transfer completes.

Function
REQ-003 States: IDLE, REQ, READ, WRITE, REL. All outputs are registered or decoded directly from state.
REQ-004 IDLE + start with len≠0: latch src, dst and len into working counters; busy=1; go to REQ.
REQ-005 IDLE + start with len=0: pulse done the next cycle; bus_req never asserts; busy stays 0.
REQ-006 REQ: bus_req=1. If bus_gnt=1, go to READ; otherwise stay in REQ.
REQ-007 READ (1 cycle): addr=src_cnt, addr_oe=1, mem_oe=1. data_in is captured into the holding register at the end of the cycle. Go to WRITE.
REQ-008 WRITE (1 cycle): addr=dst_cnt, addr_oe=1, data_oe=1, mem_we=1, data_out=holding register. At the end of the cycle: src_cnt+1, dst_cnt+1, len_cnt-1.
REQ-009 After WRITE with len_cnt=1 (last byte): go to REL.
REQ-010 REL (1 cycle): bus_req=0; all bus enables 0; done=1; busy=0 next cycle; go to IDLE.
REQ-011 bus_req stays 1 in READ and WRITE.
REQ-012 Minimum latency from grant to first write is 2 cycles.
REQ-013 Address counters wrap modulo 2^ADDR_WIDTH (0xFFFF+1 = 0x0000); no error is flagged.
REQ-014 start while busy=1 is ignored; latched parameters do not change.
REQ-015 bus_gnt falling in READ or WRITE aborts the current byte; counters do not advance; go to REQ; the byte is retried from READ.
REQ-016 addr_oe, data_oe, mem_oe and mem_we are never 1 outside READ/WRITE; mem_oe and mem_we are never 1 together.

Reset
REQ-017 reset=1 at a clk edge: state=IDLE; all outputs 0; counters and holding register 0.
REQ-018 reset mid-transfer drops bus_req and all enables on the same edge; done does not pulse.

Configuration
REQ-019 Macro DMA_CTRL_BURST_EN.
- Defined: the bus is held for the whole block (READ/WRITE pairs back-to-back, per REQ-003..REQ-010).
- Undefined (cycle-steal): after each non-final WRITE, go through a 1-cycle release with bus_req=0, then return to REQ. The CPU regains the bus between bytes; done pulses only after the final byte.

Structure
REQ-020 Package dma_ctrl_pkg holds:
- the state encoding (IDLE=0, REQ=1, READ=2, WRITE=3, REL=4);
- default width constants.
REQ-021 One sub-module, dma_addr_counter: loadable, incrementing, wrapping ADDR_WIDTH counter. It is instantiated twice (src, dst).

Verification
REQ-022 start, src=0x0010, dst=0x0080, len=3, gnt asserted 2 cycles after req -> 0x0010..0x0012 copied to 0x0080..0x0082 in 6 bus cycles; done pulses once.
REQ-023 start with len=0 -> done one cycle later; bus_req stays 0 throughout.
REQ-024 src=0xFFFF, len=2 -> second read at addr 0x0000.
REQ-025 gnt dropped during the WRITE of byte 2 of 4 -> byte 2 is re-read and re-written; 4 distinct bytes land at the destination.
REQ-026 reset asserted in READ -> next cycle bus_req=0, addr_oe=0, busy=0, no done; a following start with len=1 completes normally.
REQ-027 Without DMA_CTRL_BURST_EN, len=3 -> bus_req drops for exactly 1 cycle between bytes; with the macro defined, bus_req is continuous.

Source files
------------

// File: rtl/dma_ctrl_pkg.sv
// Shared definitions for the DMA controller: default widths and state encoding.
// The encodings IDLE..REL are fixed; STEAL is only reachable when the
// DMA_CTRL_BURST_EN macro is left undefined (cycle-steal operation).
package dma_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LEN_WIDTH  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_REL   = 3'd4,
    ST_STEAL = 3'd5
  } dma_state_e;

endpackage

// File: rtl/dma_addr_counter.sv
// Loadable, incrementing address counter; wraps modulo 2^ADDR_WIDTH silently.
module dma_addr_counter
  import dma_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] load_val,
  output logic [ADDR_WIDTH-1:0] count
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] count_r;

  // Load has priority over increment; natural overflow provides the wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {ADDR_WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (inc) begin
      count_r <= count_r + ADDR_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/dma_controller.sv
// Single-channel memory-to-memory DMA controller.
// Build option DMA_CTRL_BURST_EN: when defined the bus is held for the whole
// block; when undefined the bus is released for one cycle between bytes.
module dma_controller
  import dma_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  bus_req,
  input  logic                  bus_gnt,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  addr_oe,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_oe,
  output logic                  mem_oe,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  done
);

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  dma_state_e            state_r;
  dma_state_e            state_next_s;
  logic [LEN_WIDTH-1:0]  len_cnt_r;
  logic [DATA_WIDTH-1:0] hold_r;
  logic                  busy_r;
  logic [ADDR_WIDTH-1:0] src_cnt_s;
  logic [ADDR_WIDTH-1:0] dst_cnt_s;
  logic                  launch_s;
  logic                  capture_s;
  logic                  advance_s;
  logic                  last_byte_s;

  // Start is honoured only from IDLE, so a start while busy is ignored.
  assign launch_s    = (state_r == ST_IDLE) && start && (len != LEN_ZERO);
  // A byte only counts when the grant is still held at the end of the cycle.
  assign capture_s   = (state_r == ST_READ) && bus_gnt;
  assign advance_s   = (state_r == ST_WRITE) && bus_gnt;
  assign last_byte_s = (len_cnt_r == LEN_ONE);

  dma_addr_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_src_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (launch_s),
    .inc      (advance_s),
    .load_val (src_addr),
    .count    (src_cnt_s)
  );

  dma_addr_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_dst_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (launch_s),
    .inc      (advance_s),
    .load_val (dst_addr),
    .count    (dst_cnt_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a lost grant in READ/WRITE sends the byte back to REQ.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = (len != LEN_ZERO) ? ST_REQ : ST_REL;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus_gnt) begin
          state_next_s = ST_READ;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_READ: begin
        if (bus_gnt) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_WRITE: begin
        if (!bus_gnt) begin
          state_next_s = ST_REQ;
        end else if (last_byte_s) begin
          state_next_s = ST_REL;
        end else begin
`ifdef DMA_CTRL_BURST_EN
          state_next_s = ST_READ;
`else
          state_next_s = ST_STEAL;
`endif
        end
      end
      ST_STEAL: state_next_s = ST_REQ;
      ST_REL:   state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Remaining byte count and the read-to-write holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_cnt_r <= LEN_ZERO;
      hold_r    <= {DATA_WIDTH{1'b0}};
    end else begin
      if (launch_s) begin
        len_cnt_r <= len;
      end else if (advance_s) begin
        len_cnt_r <= len_cnt_r - LEN_ONE;
      end else begin
        len_cnt_r <= len_cnt_r;
      end
      if (capture_s) begin
        hold_r <= data_in;
      end else begin
        hold_r <= hold_r;
      end
    end
  end

  // Busy covers REQ through REL; a zero-length start never raises it.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
    end else if (launch_s) begin
      busy_r <= 1'b1;
    end else if (state_r == ST_REL) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= busy_r;
    end
  end

  // Bus outputs decoded from the state register; enables only in READ/WRITE.
  always_comb begin
    bus_req  = 1'b0;
    addr_oe  = 1'b0;
    addr     = {ADDR_WIDTH{1'b0}};
    data_oe  = 1'b0;
    data_out = {DATA_WIDTH{1'b0}};
    mem_oe   = 1'b0;
    mem_we   = 1'b0;
    done     = 1'b0;
    case (state_r)
      ST_REQ: begin
        bus_req = 1'b1;
      end
      ST_READ: begin
        bus_req = 1'b1;
        addr_oe = 1'b1;
        addr    = src_cnt_s;
        mem_oe  = 1'b1;
      end
      ST_WRITE: begin
        bus_req  = 1'b1;
        addr_oe  = 1'b1;
        addr     = dst_cnt_s;
        data_oe  = 1'b1;
        data_out = hold_r;
        mem_we   = 1'b1;
      end
      ST_REL: begin
        done = 1'b1;
      end
      default: begin
        bus_req = 1'b0;
      end
    endcase
  end

  assign busy = busy_r;

endmodule

// File: tb/tb_dma_controller.sv
// Self-checking bench for dma_controller: table of transfers with a write
// scoreboard, plus hand sequences for reset, zero length and reset mid-read.
module tb_dma_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [7:0]  len;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] addr;
  logic        addr_oe;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        mem_oe;
  logic        mem_we;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [7:0]  len;
    int          gdelay;   // cycles of REQ before the CPU grants
    int          drop;     // 1-based write index whose grant is pulled (0 = none)
    bit          restart;  // issue a stray start while busy
    int          exp_bus;  // expected cycles with addr_oe=1
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  vec_t vecs[5];
  wr_t  sb_q[$];

  dma_controller dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .bus_req  (bus_req),
    .bus_gnt  (bus_gnt),
    .addr     (addr),
    .addr_oe  (addr_oe),
    .data_in  (data_in),
    .data_out (data_out),
    .data_oe  (data_oe),
    .mem_oe   (mem_oe),
    .mem_we   (mem_we),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Source memory contents as a function of address (distinct across wrap).
  function automatic logic [7:0] pat(input logic [15:0] a);
    logic [7:0] hi3;
    hi3 = a[15:8] * 8'd3;
    return a[7:0] + hi3 + 8'hA5;
  endfunction

  assign data_in = mem_oe ? pat(addr) : 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Launch one transfer and act as CPU/memory until it completes.
  task automatic run_xfer(input vec_t v);
    int waitc, valid_wr, bus_cyc, gap_cyc, gap_runs, done_cnt, grant_at, first_wr_at, exp_gap;
    bit in_gap, seen_done, dropped, timeout, gnt_now;
    logic [15:0] rd_first, rd_last, exp_last;
    wr_t e;
    waitc = 0; valid_wr = 0; bus_cyc = 0; gap_cyc = 0; gap_runs = 0; done_cnt = 0;
    grant_at = -1; first_wr_at = -1;
    in_gap = 0; seen_done = 0; dropped = 0; timeout = 1;
    rd_first = 16'h0000; rd_last = 16'h0000;
    for (int i = 0; i < int'(v.len); i++) begin
      sb_q.push_back('{v.dst + 16'(i), pat(v.src + 16'(i))});
    end
    src_addr = v.src; dst_addr = v.dst; len = v.len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (seen_done) begin
        check("busy_after_done", busy, 1'b0);
        check("done_single_cycle", done, 1'b0);
        timeout = 0;
        break;
      end
      gnt_now = bus_gnt;
      check("rd_wr_exclusive", mem_oe & mem_we, 1'b0);
      check("enables_in_bus_states", (addr_oe | data_oe | mem_oe | mem_we) & ~bus_req, 1'b0);
      check("busy_during", busy, 1'b1);
      if (done) begin
        done_cnt++;
        seen_done = 1;
      end
      if (!bus_req && !done) begin
        gap_cyc++;
        if (!in_gap) gap_runs++;
        in_gap = 1;
      end else begin
        in_gap = 0;
      end
      if (addr_oe) bus_cyc++;
      if (mem_oe && gnt_now) begin
        if (rd_first == 16'h0000 && rd_last == 16'h0000 && first_wr_at < 0) rd_first = addr;
        rd_last = addr;
      end
      // CPU grant model: grant after gdelay cycles of request, drop on release.
      if (!bus_req) begin
        bus_gnt = 1'b0;
        waitc = 0;
      end else if (!gnt_now) begin
        if (waitc >= v.gdelay) begin
          bus_gnt = 1'b1;
          if (grant_at < 0) grant_at = cyc;
        end else begin
          waitc++;
        end
      end
      if (v.restart && cyc == 1) begin
        start = 1'b1; src_addr = 16'hDEAD; dst_addr = 16'hBEEF; len = 8'd7;
      end else begin
        start = 1'b0;
      end
      if (mem_we && gnt_now) begin
        if (v.drop != 0 && !dropped && valid_wr == v.drop - 1) begin
          bus_gnt = 1'b0;
          dropped = 1;
          waitc = 0;
        end else begin
          valid_wr++;
          if (first_wr_at < 0) first_wr_at = cyc;
          if (sb_q.size() == 0) begin
            check("unexpected_write", 1'b1, 1'b0);
          end else begin
            e = sb_q.pop_front();
            check("write_addr", addr, e.a);
            check("write_data", data_out, e.d);
          end
        end
      end
      @(negedge clk);
    end
    bus_gnt = 1'b0;
    start = 1'b0;
    if (timeout) check("transfer_timeout", 1'b1, 1'b0);
    check("done_count", done_cnt, 1);
    check("writes_missing", sb_q.size(), 0);
    sb_q.delete();
    check("bus_cycles", bus_cyc, v.exp_bus);
    check("grant_to_first_write", first_wr_at - grant_at, 2);
    exp_last = v.src + 16'(v.len) - 16'd1;
    check("first_read_addr", rd_first, v.src);
    check("last_read_addr", rd_last, exp_last);
`ifdef DMA_CTRL_BURST_EN
    exp_gap = 0;
`else
    exp_gap = int'(v.len) - 1;
`endif
    check("req_gap_cycles", gap_cyc, exp_gap);
    check("req_gap_runs", gap_runs, exp_gap);
  endtask

  initial begin
    vecs[0] = '{16'h0010, 16'h0080, 8'd3, 2, 0, 1'b0, 6};
    vecs[1] = '{16'hFFFF, 16'h0200, 8'd2, 1, 0, 1'b0, 4};
    vecs[2] = '{16'h1234, 16'h4000, 8'd4, 0, 2, 1'b0, 10};
    vecs[3] = '{16'h0300, 16'hFFFE, 8'd3, 3, 0, 1'b1, 6};
    vecs[4] = '{16'h0050, 16'h0060, 8'd1, 0, 0, 1'b0, 2};

    reset = 1'b1; start = 1'b0; bus_gnt = 1'b0;
    src_addr = 16'h0000; dst_addr = 16'h0000; len = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_ctrl_outputs", {bus_req, addr_oe, data_oe, mem_oe, mem_we, busy, done}, 7'b0);
    check("reset_addr", addr, 16'h0000);
    check("reset_data_out", data_out, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven transfers.
    for (int k = 0; k < 5; k++) begin
      run_xfer(vecs[k]);
      repeat (2) @(negedge clk);
    end

    // Zero-length start: done one cycle later, no bus request, never busy.
    src_addr = 16'h0100; dst_addr = 16'h0200; len = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("len0_done", done, 1'b1);
    check("len0_req_busy", {bus_req, busy}, 2'b00);
    @(negedge clk);
    check("len0_done_drop", done, 1'b0);
    check("len0_req_busy_after", {bus_req, busy}, 2'b00);
    repeat (2) @(negedge clk);

    // Reset while in READ: everything drops, no done, then a clean transfer.
    src_addr = 16'h0500; dst_addr = 16'h0600; len = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus_gnt = 1'b1;
    for (int k = 0; k < 20 && !mem_oe; k++) @(negedge clk);
    check("reached_read", mem_oe, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus_gnt = 1'b0;
    check("rst_mid_bus_req", bus_req, 1'b0);
    check("rst_mid_addr_oe", addr_oe, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_mid_quiet", {done, bus_req, busy}, 3'b000);
    end
    run_xfer('{16'h0700, 16'h0800, 8'd1, 1, 0, 1'b0, 2});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=expired required=finished");
    $fatal(1, "watchdog");
  end

endmodule
